// File: rtl/vga_pkg.sv
// ============================================================
// vga_pkg: shared VGA geometry, RAM widths and arbiter types.
// Rev 1.0
// ============================================================
`default_nettype none

package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 16;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;

  localparam int FIFO_DEPTH = 8;
  localparam int LOW_WATER  = 4;
  localparam int RD_LAT     = 2;

  typedef struct packed {
    logic [RGB_R_W-1:0] r;
    logic [RGB_G_W-1:0] g;
    logic [RGB_B_W-1:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } gnt_e;

endpackage

`default_nettype wire

// File: rtl/vga_pix_fifo.sv
// ============================================================
// vga_pix_fifo: show-ahead pixel FIFO with occupancy count and flush.
// Rev 1.0
// ============================================================
`default_nettype none

module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// ============================================================
// vga_fb_arbiter: single-port frame-buffer arbiter, display prefetch vs writer.
// Rev 1.0
// ============================================================
`default_nettype none

module vga_fb_arbiter #(
  parameter int ADDR_W       = vga_pkg::ADDR_W,
  parameter int DATA_W       = vga_pkg::DATA_W,
  parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS,
  parameter int FIFO_DEPTH   = vga_pkg::FIFO_DEPTH,
  parameter int LOW_WATER    = vga_pkg::LOW_WATER,
  parameter int RD_LAT       = vga_pkg::RD_LAT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_start_i,
  input  logic              pix_pop_i,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              pix_valid_o,
  output logic              underflow_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  import vga_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic              underflow_q, underflow_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_valid;
  logic              fifo_push;
  logic              fifo_pop;
  logic              wr_in_range;
  gnt_e              gnt;
  int                occ;

  // Reads still in the pipe count toward occupancy so the FIFO can never overflow.
  always_comb begin
    occ = int'(fifo_count);
    for (int k = 0; k < RD_LAT; k++) occ = occ + int'(pipe_q[k]);
    gnt = GNT_NONE;
    if (frame_start_i)                  gnt = GNT_NONE;
    else if (occ < LOW_WATER)           gnt = GNT_READ;
    else if (wr_req_i && !wr_ack_q)     gnt = GNT_WRITE;
    else if (occ < FIFO_DEPTH)          gnt = GNT_READ;
  end

  assign wr_in_range = (wr_addr_i < ADDR_W'(FRAME_PIXELS));

  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    wr_ack_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    pipe_d      = pipe_q << 1;
    underflow_d = underflow_q | (pix_pop_i && !fifo_valid);
    if (frame_start_i) begin
      pipe_d      = '0;
      rd_addr_d   = '0;
      underflow_d = 1'b0;
    end
    case (gnt)
      GNT_READ: begin
        mem_en_d   = 1'b1;
        mem_addr_d = rd_addr_q;
        pipe_d[0]  = 1'b1;
        rd_addr_d  = (rd_addr_q == ADDR_W'(FRAME_PIXELS - 1)) ? '0 : rd_addr_q + ADDR_W'(1);
      end
      GNT_WRITE: begin
        wr_ack_d = 1'b1;
        if (wr_in_range) begin
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_i;
          mem_wdata_d = wr_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q      <= '0;
      rd_addr_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pipe_q      <= pipe_d;
      rd_addr_q   <= rd_addr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_push = pipe_q[RD_LAT-1] && !frame_start_i;
  assign fifo_pop  = pix_pop_i && fifo_valid && !frame_start_i;

  vga_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (frame_start_i),
    .push_i  (fifo_push),
    .data_i  (mem_rdata_i),
    .pop_i   (fifo_pop),
    .data_o  (pix_data_o),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign pix_valid_o = fifo_valid;
  assign underflow_o = underflow_q;
  assign wr_ack_o    = wr_ack_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// ============================================================
// tb_vga_fb_arbiter: randomized bench against a queue-based reference model.
// Rev 1.0
// ============================================================
`default_nettype none

module tb_vga_fb_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 16;
  localparam int FP    = 200;
  localparam int DEPTH = 8;
  localparam int LW    = 4;
  localparam int RL    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fs = 1'b0;
  logic          pop = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          underflow;
  logic          wr_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP),
    .FIFO_DEPTH(DEPTH), .LOW_WATER(LW), .RD_LAT(RL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .frame_start_i(fs), .pix_pop_i(pop),
    .pix_data_o(pix_data), .pix_valid_o(pix_valid), .underflow_o(underflow),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [DW-1:0] pat(int a);
    return DW'(a * 37 + 4660);
  endfunction

  // Synchronous RAM: data for a strobe seen on an edge is presented the next cycle.
  logic [DW-1:0] ram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : pat(int'(mem_addr));
    end
  end

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  logic [DW-1:0] mq [$];
  rd_t           infl [$];
  logic [DW-1:0] img [int];
  int            cyc;
  int            m_addr;
  bit            m_uf, e_en, e_we, e_ack;
  int            e_addr;
  logic [DW-1:0] e_wdata;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [DW-1:0] img_rd(int a);
    return img.exists(a) ? img[a] : pat(a);
  endfunction

  task automatic model_reset();
    mq.delete();
    infl.delete();
    cyc = 0; m_addr = 0; m_uf = 0;
    e_en = 0; e_we = 0; e_ack = 0; e_addr = 0; e_wdata = '0;
  endtask

  // One clock edge of the reference: decide from current occupancy, then apply pops/pushes.
  task automatic model_step();
    int  occ;
    int  g;
    rd_t r;
    if (rst) begin
      model_reset();
      return;
    end
    occ = mq.size() + infl.size();
    g = 0;
    if (fs)                    g = 0;
    else if (occ < LW)         g = 1;
    else if (wr_req && !e_ack) g = 2;
    else if (occ < DEPTH)      g = 1;
    if (fs) begin
      mq.delete();
      infl.delete();
      m_addr = 0;
      m_uf = 0;
    end else begin
      if (pop) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_uf = 1;
      end
      if (infl.size() > 0 && infl[0].due == cyc) begin
        mq.push_back(infl[0].d);
        void'(infl.pop_front());
      end
    end
    e_en = 0; e_we = 0; e_ack = 0; e_addr = 0; e_wdata = '0;
    if (g == 1) begin
      e_en = 1;
      e_addr = m_addr;
      r.due = cyc + RL;
      r.d = img_rd(m_addr);
      infl.push_back(r);
      m_addr = (m_addr + 1) % FP;
    end else if (g == 2) begin
      e_ack = 1;
      if (int'(wr_addr) < FP) begin
        e_en = 1; e_we = 1;
        e_addr = int'(wr_addr);
        e_wdata = wr_data;
        img[e_addr] = wr_data;
      end
    end
    cyc++;
  endtask

  task automatic compare();
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("wr_ack", wr_ack, e_ack);
    chk("pix_valid", pix_valid, mq.size() > 0);
    chk("pix_data", pix_data, (mq.size() > 0) ? mq[0] : '0);
    chk("underflow", underflow, m_uf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic new_req();
    wr_req = 1'b1;
    case ($urandom_range(0, 15))
      0:       wr_addr = AW'(FP - 1);
      1:       wr_addr = AW'(FP);
      2:       wr_addr = AW'(FP + 1);
      3:       wr_addr = '1;
      default: wr_addr = AW'($urandom_range(0, FP - 1));
    endcase
    wr_data = DW'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int popp;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Prefetch after reset: first read at address 0, data visible two cycles later.
    tick();
    chk("first_rd_en", mem_en, 1);
    chk("first_rd_addr", mem_addr, 0);
    tick();
    tick();
    chk("first_valid", pix_valid, 1);
    chk("first_data", pix_data, pat(0));
    repeat (8) tick();
    chk("idle_when_full", mem_en, 0);

    // Write granted with the FIFO full, held request not re-granted.
    wr_req = 1'b1; wr_addr = AW'(100); wr_data = 16'hF800;
    tick();
    chk("wr_grant_ack", wr_ack, 1);
    chk("wr_grant_we", mem_we, 1);
    chk("wr_grant_addr", mem_addr, 100);
    chk("wr_grant_data", mem_wdata, 16'hF800);
    tick();
    chk("wr_no_regrant", wr_ack, 0);
    wr_req = 1'b0;

    pop = 1'b1;
    repeat (20) tick();

    // Underflow after a flush, sticky until the next frame start.
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("fs_flush_valid", pix_valid, 0);
    tick();
    chk("uf_set", underflow, 1);
    chk("fs_rd_addr0", mem_addr, 0);
    chk("fs_rd_en", mem_en, 1);
    repeat (4) tick();
    chk("uf_sticky", underflow, 1);
    pop = 1'b0;
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("uf_clear", underflow, 0);

    // Out-of-range write is acknowledged without a RAM strobe.
    wr_req = 1'b1; wr_addr = AW'(FP); wr_data = 16'h07E0;
    for (int k = 0; k < 20 && !wr_ack; k++) tick();
    chk("drop_ack_seen", wr_ack, 1);
    chk("drop_en", mem_en, 0);
    wr_req = 1'b0;
    tick();

    for (int i = 0; i < 4000; i++) begin
      case ((i / 400) % 3)
        0:       popp = 20;
        1:       popp = 55;
        default: popp = 95;
      endcase
      fs  = ($urandom_range(0, 199) == 0);
      pop = ($urandom_range(0, 99) < popp);
      if (wr_ack) begin
        if ($urandom_range(0, 1) == 0) wr_req = 1'b0;
        else new_req();
      end else if (!wr_req && $urandom_range(0, 3) == 0) begin
        new_req();
      end
      if (i == 2000) begin
        new_req();
        do_reset(3);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
